// File: rtl/fifo_half_packer_pkg.sv
// Shared FIFO word layout and packer state encoding, used by every packer
// that sits on a 9-bit FWFT byte FIFO.
package fifo_half_packer_pkg;

  localparam int FIFO_DEPTH    = 16;
  localparam int FIFO_AW       = 4;
  localparam int FIFO_W        = 9;
  localparam int FIFO_BYTE_LSB = 0;
  localparam int FIFO_BYTE_MSB = 7;
  localparam int FIFO_EOP_BIT  = 8;

  typedef enum logic {
    PK_LO = 1'b0,
    PK_HI = 1'b1
  } pack_state_e;

  function automatic logic [7:0] fifo_byte(input logic [FIFO_W-1:0] w);
    return w[FIFO_BYTE_MSB:FIFO_BYTE_LSB];
  endfunction

  function automatic logic fifo_eop(input logic [FIFO_W-1:0] w);
    return w[FIFO_EOP_BIT];
  endfunction

endpackage

// File: rtl/fifo_fwft_16x9.sv
// 16-deep, 9-bit first-word-fall-through FIFO: Dout shows the head word
// whenever Empty is low; RdEn pops it.
module fifo_fwft_16x9
  import fifo_half_packer_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [FIFO_W-1:0] Din,
  input  logic              WrEn,
  input  logic              RdEn,
  output logic [FIFO_W-1:0] Dout,
  output logic              Empty,
  output logic              Full,
  output logic              Valid,
  output logic [FIFO_AW:0]  DataCount
);

  logic [FIFO_W-1:0]  mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               wr_ok, rd_ok;

  assign Empty     = (count_q == '0);
  assign Full      = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
  assign Valid     = ~Empty;
  assign DataCount = count_q;
  assign Dout      = mem_q[rd_ptr_q];

  assign wr_ok = WrEn & ~Full;
  assign rd_ok = RdEn & ~Empty;

  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= Din;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_half_packer.sv
// Packs bytes from an FWFT FIFO into halfwords (first byte low); a packet
// ending on a low byte is padded and flagged odd.
module fifo_half_packer
  import fifo_half_packer_pkg::*;
#(
  parameter logic [7:0] PadByte    = 8'h00,
  parameter int         CountWidth = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [FIFO_W-1:0]     FifoDout,
  input  logic                  FifoEmpty,
  output logic                  FifoRead,
  output logic [15:0]           OutData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic                  OutLast,
  output logic                  OutOdd,
  output logic [CountWidth-1:0] PacketCount
);

  pack_state_e           state_q;
  logic [7:0]            low_q;
  logic [15:0]           data_q;
  logic                  valid_q, last_q, odd_q;
  logic [CountWidth-1:0] pkt_cnt_q, pkt_cnt_d;
  logic                  pop, accept;
  logic [7:0]            in_byte;
  logic                  in_eop;

  assign in_byte   = fifo_byte(FifoDout);
  assign in_eop    = fifo_eop(FifoDout);
  assign accept    = valid_q & OutReady;
  // Pop only when the output register is free or is draining this cycle.
  assign pop       = ~Reset & ~FifoEmpty & (~valid_q | OutReady);
  assign pkt_cnt_d = pkt_cnt_q + CountWidth'(1);

  assign FifoRead    = pop;
  assign OutData     = data_q;
  assign OutValid    = valid_q;
  assign OutLast     = last_q;
  assign OutOdd      = odd_q;
  assign PacketCount = pkt_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= PK_LO;
      low_q     <= 8'h00;
      data_q    <= 16'h0000;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      odd_q     <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      if (accept) begin
        valid_q <= 1'b0;
        if (last_q) pkt_cnt_q <= pkt_cnt_d;
      end
      // A load below overrides the clear above, giving back-to-back transfers.
      if (pop) begin
        case (state_q)
          PK_LO: begin
            if (in_eop) begin
              data_q  <= {PadByte, in_byte};
              last_q  <= 1'b1;
              odd_q   <= 1'b1;
              valid_q <= 1'b1;
            end else begin
              low_q   <= in_byte;
              state_q <= PK_HI;
            end
          end
          PK_HI: begin
            data_q  <= {in_byte, low_q};
            last_q  <= in_eop;
            odd_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= PK_LO;
          end
          default: state_q <= PK_LO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_half_packer.sv
// Directed bench: two packers (default and PadByte=FF/CountWidth=4), each fed
// by a 16x9 FWFT FIFO; accepted halfwords are logged and checked in order.
module tb_fifo_half_packer;
  import fifo_half_packer_pkg::*;

  logic Clk, Reset, fifo_rst;

  logic [8:0]  a_din, a_dout;
  logic        a_wr, a_empty, a_full, a_fvalid, a_rd;
  logic [4:0]  a_fcnt;
  logic [15:0] a_data;
  logic        a_vld, a_rdy, a_last, a_odd;
  logic [15:0] a_pc;

  logic [8:0]  b_din, b_dout;
  logic        b_wr, b_empty, b_full, b_fvalid, b_rd;
  logic [4:0]  b_fcnt;
  logic [15:0] b_data;
  logic        b_vld, b_rdy, b_last, b_odd;
  logic [3:0]  b_pc;

  typedef struct {
    logic        last;
    logic        odd;
    logic [15:0] data;
    int          cyc;
  } rec_t;

  rec_t qa[$];
  rec_t qb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  fifo_fwft_16x9 u_fifo_a (
    .Clk(Clk), .Reset(fifo_rst), .Din(a_din), .WrEn(a_wr), .RdEn(a_rd),
    .Dout(a_dout), .Empty(a_empty), .Full(a_full), .Valid(a_fvalid),
    .DataCount(a_fcnt)
  );

  fifo_half_packer dut (
    .Clk(Clk), .Reset(Reset), .FifoDout(a_dout), .FifoEmpty(a_empty),
    .FifoRead(a_rd), .OutData(a_data), .OutValid(a_vld), .OutReady(a_rdy),
    .OutLast(a_last), .OutOdd(a_odd), .PacketCount(a_pc)
  );

  fifo_fwft_16x9 u_fifo_b (
    .Clk(Clk), .Reset(fifo_rst), .Din(b_din), .WrEn(b_wr), .RdEn(b_rd),
    .Dout(b_dout), .Empty(b_empty), .Full(b_full), .Valid(b_fvalid),
    .DataCount(b_fcnt)
  );

  fifo_half_packer #(.PadByte(8'hFF), .CountWidth(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .FifoDout(b_dout), .FifoEmpty(b_empty),
    .FifoRead(b_rd), .OutData(b_data), .OutValid(b_vld), .OutReady(b_rdy),
    .OutLast(b_last), .OutOdd(b_odd), .PacketCount(b_pc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  // Handshakes are logged mid-cycle; inputs only change just after posedge.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (a_vld && a_rdy) qa.push_back('{a_last, a_odd, a_data, cyc});
      if (b_vld && b_rdy) qb.push_back('{b_last, b_odd, b_data, cyc});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit isb, input int idx, input logic [17:0] exp);
    logic [17:0] obs;
    obs = 'x;
    if (!isb && idx < qa.size()) obs = {qa[idx].last, qa[idx].odd, qa[idx].data};
    if (isb && idx < qb.size())  obs = {qb[idx].last, qb[idx].odd, qb[idx].data};
    check(tag, 32'(obs), 32'(exp));
  endtask

  function automatic int gap_a(input int idx);
    if (idx + 1 >= qa.size()) return -1;
    return qa[idx+1].cyc - qa[idx].cyc;
  endfunction

  task automatic wait_out(input string tag, input bit isb, input int n);
    int k;
    k = 0;
    while ((isb ? qb.size() : qa.size()) < n && k < 200) begin
      tick();
      k++;
    end
    check(tag, isb ? qb.size() : qa.size(), n);
  endtask

  task automatic push_a(input logic [8:0] w);
    a_din = w; a_wr = 1'b1;
    tick();
    a_wr = 1'b0;
  endtask

  task automatic push_b(input logic [8:0] w);
    b_din = w; b_wr = 1'b1;
    tick();
    b_wr = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; fifo_rst = 1'b1;
    a_din = '0; a_wr = 1'b0; a_rdy = 1'b0;
    b_din = '0; b_wr = 1'b0; b_rdy = 1'b0;
    tick(); tick();

    // reset state, and no pop while Reset is high even with data waiting
    fifo_rst = 1'b0;
    check("rst_valid", a_vld, 0);
    check("rst_data", a_data, 16'h0000);
    check("rst_last_odd", {a_last, a_odd}, 0);
    check("rst_pc", a_pc, 0);
    check("rst_pc_b", b_pc, 0);
    push_a(9'h0EE);
    check("rst_fifo_nonempty", a_empty, 0);
    check("rst_no_read", a_rd, 0);
    fifo_rst = 1'b1; tick(); fifo_rst = 1'b0;
    Reset = 1'b0; tick();

    // two-halfword packet ending odd; second output follows with no bubble
    a_rdy = 1'b1;
    push_a(9'h011); push_a(9'h022); push_a(9'h133);
    wait_out("t1_wait", 0, 2);
    tick(); tick();
    chk_out("t1_out0", 0, 0, {2'b00, 16'h2211});
    chk_out("t1_out1", 0, 1, {2'b11, 16'h0033});
    check("t1_b2b_gap", gap_a(0), 1);
    check("t1_pc", a_pc, 1);
    qa.delete();

    // lone last byte, default and FF padding
    push_a(9'h1A5);
    wait_out("t2_wait", 0, 1);
    tick(); tick();
    chk_out("t2_out", 0, 0, {2'b11, 16'h00A5});
    check("t2_pc", a_pc, 2);
    qa.delete();
    b_rdy = 1'b1;
    push_b(9'h1A5);
    wait_out("t2b_wait", 1, 1);
    tick(); tick();
    chk_out("t2b_out", 1, 0, {2'b11, 16'hFFA5});
    check("t2b_pc", b_pc, 1);
    qb.delete();

    // stall with OutReady low: no pops, output held, then drain in order
    a_rdy = 1'b0;
    for (int i = 0; i < 8; i++) push_a({(i == 7), 8'(i)});
    for (int i = 0; i < 10; i++) begin
      check("t3_stall_rd", a_rd, 0);
      check("t3_stall_data", {a_vld, a_data}, {1'b1, 16'h0100});
      tick();
    end
    a_rdy = 1'b1;
    wait_out("t3_wait", 0, 4);
    tick(); tick();
    chk_out("t3_out0", 0, 0, {2'b00, 16'h0100});
    chk_out("t3_out1", 0, 1, {2'b00, 16'h0302});
    chk_out("t3_out2", 0, 2, {2'b00, 16'h0504});
    chk_out("t3_out3", 0, 3, {2'b10, 16'h0706});
    check("t3_pc", a_pc, 3);
    qa.delete();

    // reset while holding a low byte discards it
    push_a(9'h044);
    tick();
    Reset = 1'b1; a_din = 9'h055; a_wr = 1'b1;
    check("t4_rd_in_reset", a_rd, 0);
    tick();
    Reset = 1'b0;
    check("t4_post_valid", a_vld, 0);
    check("t4_post_pc", a_pc, 0);
    a_din = 9'h166;
    tick();
    a_wr = 1'b0;
    wait_out("t4_wait", 0, 1);
    tick(); tick(); tick(); tick();
    check("t4_count", qa.size(), 1);
    chk_out("t4_out", 0, 0, {2'b10, 16'h6655});
    check("t4_pc", a_pc, 1);
    qa.delete();

    // continuous traffic: a halfword every 2 cycles
    for (int i = 0; i < 10; i++) push_a({(i == 9), 8'(8'h10 + i)});
    wait_out("t5_wait", 0, 5);
    tick(); tick();
    chk_out("t5_out0", 0, 0, {2'b00, 16'h1110});
    chk_out("t5_out1", 0, 1, {2'b00, 16'h1312});
    chk_out("t5_out2", 0, 2, {2'b00, 16'h1514});
    chk_out("t5_out3", 0, 3, {2'b00, 16'h1716});
    chk_out("t5_out4", 0, 4, {2'b10, 16'h1918});
    for (int i = 0; i < 4; i++) check("t5_gap", gap_a(i), 2);
    check("t5_pc", a_pc, 2);
    qa.delete();

    // 4-bit packet counter wraps after 16 packets
    Reset = 1'b1; tick(); Reset = 1'b0;
    qb.delete();
    check("t6_pc_rst", b_pc, 0);
    for (int i = 0; i < 17; i++) push_b({1'b1, 8'(8'h20 + i)});
    wait_out("t6_wait", 1, 17);
    tick(); tick(); tick();
    chk_out("t6_first", 1, 0, {2'b11, 16'hFF20});
    chk_out("t6_last", 1, 16, {2'b11, 16'hFF30});
    check("t6_pc_wrap", b_pc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
